// File: rtl/approx_mul_ha_pipe_if.sv
// Streaming operand/result bundle for approx_mul_ha_pipe.
// The source drives through master; the multiplier sits on slave.
interface approx_mul_ha_pipe_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic           approx_en;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;
  logic [2*N-1:0] p_exact;
  logic           mismatch;

  modport master (
    output in_valid, approx_en, x, y, out_ready,
    input  in_ready, out_valid, p, p_exact, mismatch
  );

  modport slave (
    input  in_valid, approx_en, x, y, out_ready,
    output in_ready, out_valid, p, p_exact, mismatch
  );
endinterface

// File: rtl/approx_mul_ha_pipe.sv
// Two-stage unsigned NxN approximate multiplier: per-cell programmable half-adder
// compression of row pairs (S1), then final summation and mismatch flagging (S2).
module approx_mul_ha_pipe #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*(N-1)-1:0] cfg_mode,
  input  logic               cfg_load,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   mismatch_cnt,
  approx_mul_ha_pipe_if.slave bus
);

  localparam int PAIRS   = N / 2;
  localparam int CELLS   = N - 1;
  localparam int MODE_W  = N * (N - 1);
  localparam int PAIR_W  = 2 * N;        // {b[N-2:0], t[N:0]}
  localparam int SUM_W   = 2 * N + 1;

  generate
    if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
      $error("approx_mul_ha_pipe: N must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    HA_EXACT  = 2'b00,
    HA_OR     = 2'b01,
    HA_ACARRY = 2'b10,
    HA_ELIM   = 2'b11
  } ha_mode_e;

  // Returns {carry, sum} for one configurable half-adder cell.
  function automatic logic [1:0] ha_cell(input logic [1:0] mode, input logic a, input logic b);
    logic [1:0] cs;
    case (mode)
      HA_EXACT:  cs = {a & b, a ^ b};
      HA_OR:     cs = {1'b0, a | b};
      HA_ACARRY: cs = {a, 1'b0};
      default:   cs = 2'b00;
    endcase
    return cs;
  endfunction

  // Compresses rows 2k (row_lo) and 2k+1 (row_hi) into {b, t}.
  function automatic logic [PAIR_W-1:0] compress_pair(
    input logic [N-1:0]         row_lo,
    input logic [N-1:0]         row_hi,
    input logic [2*CELLS-1:0]   modes
  );
    logic [N:0]   t;
    logic [N-2:0] bv;
    logic [1:0]   cs;
    t      = '0;
    bv     = '0;
    t[0]   = row_lo[0];
    bv[N-2] = row_hi[N-1];
    for (int j = 0; j < CELLS; j++) begin
      cs       = ha_cell(modes[2*j +: 2], row_lo[j+1], row_hi[j]);
      t[j+1]   = cs[0];
      if (j < N - 2) bv[j] = cs[1];
      else           t[N]  = cs[1];
    end
    return {bv, t};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_load;
  logic s2_load;
  logic accept;

  assign s2_load      = !bus.out_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;
  assign accept       = bus.in_valid && s1_load;

  // ---------------------------------------------------------------------------
  // Mode register
  // ---------------------------------------------------------------------------
  logic [MODE_W-1:0] mode_q;

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values; a blocking = here would leak new values into same-edge reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mode_q <= '0;
    else if (cfg_load) mode_q <= cfg_mode;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 input logic: partial products and row-pair compression
  // ---------------------------------------------------------------------------
  logic [MODE_W-1:0]             eff_mode;
  logic [PAIRS-1:0][PAIR_W-1:0]  pair_d;
  logic [2*N-1:0]                exact_d;

  assign eff_mode = bus.approx_en ? mode_q : '0;
  assign exact_d  = (2*N)'(bus.x) * (2*N)'(bus.y);

  // NOTE: the default assignment ahead of the loop guarantees every bit is
  // written on every pass, so no latch can be inferred.
  always_comb begin
    pair_d = '0;
    for (int k = 0; k < PAIRS; k++) begin
      pair_d[k] = compress_pair(bus.y & {N{bus.x[2*k]}},
                                bus.y & {N{bus.x[2*k+1]}},
                                eff_mode[2*CELLS*k +: 2*CELLS]);
    end
  end

  logic [PAIRS-1:0][PAIR_W-1:0] s1_pair;
  logic [2*N-1:0]               s1_exact;

  // NOTE: the data registers are reset as well as the valid bits, so the
  // outputs read a defined zero after reset instead of stale pipeline contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pair  <= '0;
      s1_exact <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_pair  <= pair_d;
        s1_exact <= exact_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 input logic: weighted sum of pair values with saturation
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] sum_w;
  logic [2*N-1:0]   p_d;
  logic             mismatch_d;

  always_comb begin
    sum_w = '0;
    for (int k = 0; k < PAIRS; k++) begin
      sum_w = sum_w + ((SUM_W'(s1_pair[k][N:0]) +
                        (SUM_W'(s1_pair[k][PAIR_W-1:N+1]) << 2)) << (2*k));
    end
  end

  assign p_d        = sum_w[2*N] ? '1 : sum_w[2*N-1:0];
  assign mismatch_d = (p_d != s1_exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.p         <= '0;
      bus.p_exact   <= '0;
      bus.mismatch  <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.p        <= p_d;
        bus.p_exact  <= s1_exact;
        bus.mismatch <= mismatch_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mismatch counter: counts delivered results only; clear has priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (cnt_clr) begin
      mismatch_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.mismatch && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Directed bench for approx_mul_ha_pipe (N=8): vector table, streaming, stall,
// same-edge config load, counter saturation/clear and mid-flight reset.
module tb_approx_mul_ha_pipe;

  localparam int N      = 8;
  localparam int MODE_W = N * (N - 1);

  logic              clk;
  logic              rst_n;
  logic [MODE_W-1:0] cfg_mode;
  logic              cfg_load;
  logic              cnt_clr;
  logic [15:0]       cnt;
  logic [1:0]        cnt2;

  approx_mul_ha_pipe_if #(.N(N)) bus ();
  approx_mul_ha_pipe_if #(.N(N)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.approx_en = bus.approx_en;
  assign bus2.x         = bus.x;
  assign bus2.y         = bus.y;
  assign bus2.out_ready = bus.out_ready;

  approx_mul_ha_pipe #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_load(cfg_load),
    .cnt_clr(cnt_clr), .mismatch_cnt(cnt), .bus(bus)
  );

  approx_mul_ha_pipe #(.N(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_load(cfg_load),
    .cnt_clr(cnt_clr), .mismatch_cnt(cnt2), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else             n_pass++;
  endtask

  function automatic logic [MODE_W-1:0] fill(input logic [1:0] m);
    logic [MODE_W-1:0] v;
    for (int c = 0; c < MODE_W / 2; c++) v[2*c +: 2] = m;
    return v;
  endfunction

  task automatic load_cfg(input logic [MODE_W-1:0] v);
    @(negedge clk);
    cfg_mode = v;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Sends one operand pair into an idle pipe and returns the result at the
  // first cycle out_valid is seen; lat counts negedges after the accept edge.
  task automatic send_and_get(input logic [7:0] xv, input logic [7:0] yv, input logic en,
                              output logic [15:0] pr, output logic [15:0] pe,
                              output logic mm, output int lat);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.x         = xv;
    bus.y         = yv;
    bus.approx_en = en;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    pr = bus.p;
    pe = bus.p_exact;
    mm = bus.mismatch;
  endtask

  typedef struct {
    logic [MODE_W-1:0] cfg;
    logic [7:0]        x;
    logic [7:0]        y;
    logic              en;
    logic [15:0]       exp_p;
    logic [15:0]       exp_pe;
    logic              exp_mm;
  } vec_t;

  vec_t        vecs[14];
  logic [15:0] sb[$];
  int          tq[$];

  initial begin
    logic [15:0] pr, pe, e;
    logic        mm;
    int          lat, t, exp_cnt;
    int          err_p, err_mm, err_t, err_rdy, n_res;
    int          sent, got, order_err, stable_err, ov_after;
    logic [7:0]  xr, yr;
    logic [15:0] held_p, held_pe;
    logic        held_mm;
    logic [7:0]  sx[4];
    logic [7:0]  sy[4];

    vecs[0]  = '{fill(2'b00), 8'd255, 8'd255, 1'b1, 16'd65025, 16'd65025, 1'b0};
    vecs[1]  = '{fill(2'b11), 8'd255, 8'd255, 1'b1, 16'd21845, 16'd65025, 1'b1};
    vecs[2]  = '{fill(2'b01), 8'd255, 8'd255, 1'b1, 16'd43435, 16'd65025, 1'b1};
    vecs[3]  = '{fill(2'b01), 8'd255, 8'd255, 1'b0, 16'd65025, 16'd65025, 1'b0};
    vecs[4]  = '{fill(2'b00), 8'd13,  8'd11,  1'b1, 16'd143,   16'd143,   1'b0};
    vecs[5]  = '{fill(2'b11), 8'd3,   8'd3,   1'b1, 16'd1,     16'd9,     1'b1};
    vecs[6]  = '{fill(2'b10), 8'd255, 8'd255, 1'b1, 16'd65025, 16'd65025, 1'b0};
    vecs[7]  = '{fill(2'b10), 8'h55,  8'd255, 1'b1, 16'd43265, 16'd21675, 1'b1};
    vecs[8]  = '{fill(2'b00), 8'd0,   8'd200, 1'b1, 16'd0,     16'd0,     1'b0};
    vecs[9]  = '{fill(2'b11), 8'd1,   8'd1,   1'b1, 16'd1,     16'd1,     1'b0};
    vecs[10] = '{fill(2'b01), 8'd2,   8'd3,   1'b1, 16'd6,     16'd6,     1'b0};
    vecs[11] = '{fill(2'b11), 8'd2,   8'd3,   1'b1, 16'd0,     16'd6,     1'b1};
    vecs[12] = '{56'h3,       8'd1,   8'd3,   1'b1, 16'd1,     16'd3,     1'b1};
    vecs[13] = '{56'hC000,    8'd4,   8'd3,   1'b1, 16'd4,     16'd12,    1'b1};

    rst_n = 1'b0; cfg_mode = '0; cfg_load = 1'b0; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.approx_en = 1'b1;
    bus.x = '0; bus.y = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_p",         bus.p, 0);
    check("rst_p_exact",   bus.p_exact, 0);
    check("rst_mismatch",  bus.mismatch, 0);
    check("rst_cnt",       cnt, 0);
    rst_n = 1'b1;

    // Streaming exact mode, one operand pair per cycle
    load_cfg(fill(2'b00));
    err_p = 0; err_mm = 0; err_t = 0; err_rdy = 0; n_res = 0;
    for (int cyc = 0; cyc < 1010; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (sb.size() == 0) err_p++;
        else begin
          e = sb.pop_front();
          t = tq.pop_front();
          if (bus.p !== e || bus.p_exact !== e) err_p++;
          if (bus.mismatch !== 1'b0) err_mm++;
          if (cyc != t + 2) err_t++;
          n_res++;
        end
      end
      if (cyc < 1000) begin
        if (!bus.in_ready) err_rdy++;
        xr = (cyc == 0) ? 8'd255 : (cyc == 1) ? 8'd0 : 8'($urandom);
        yr = (cyc == 0) ? 8'd255 : 8'($urandom);
        bus.x = xr; bus.y = yr; bus.in_valid = 1'b1;
        sb.push_back(16'(xr) * 16'(yr));
        tq.push_back(cyc);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("stream_results", n_res, 1000);
    check("stream_value_errs", err_p, 0);
    check("stream_mismatch_errs", err_mm, 0);
    check("stream_timing_errs", err_t, 0);
    check("stream_in_ready_errs", err_rdy, 0);
    check("stream_cnt", cnt, 0);

    // Directed vector table
    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      load_cfg(vecs[i].cfg);
      send_and_get(vecs[i].x, vecs[i].y, vecs[i].en, pr, pe, mm, lat);
      check($sformatf("vec%0d_p", i), pr, vecs[i].exp_p);
      check($sformatf("vec%0d_p_exact", i), pe, vecs[i].exp_pe);
      check($sformatf("vec%0d_mismatch", i), mm, vecs[i].exp_mm);
      check($sformatf("vec%0d_latency", i), lat, 2);
      if (vecs[i].exp_mm) exp_cnt++;
    end
    @(negedge clk);
    check("table_cnt", cnt, exp_cnt);
    check("table_cnt_sat2", cnt2, (exp_cnt > 3) ? 3 : exp_cnt);

    // Clear on the same cycle as a mismatching handshake
    load_cfg(fill(2'b11));
    @(negedge clk);
    bus.x = 8'd255; bus.y = 8'd255; bus.approx_en = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("clr_out_valid", bus.out_valid, 1);
    check("clr_mismatch", bus.mismatch, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_cnt", cnt, 0);
    check("clr_cnt2", cnt2, 0);

    // Back-pressure: 4 transactions, out_ready low for the first 7 cycles
    load_cfg(fill(2'b00));
    sx = '{8'd3, 8'd7, 8'd11, 8'd200};
    sy = '{8'd5, 8'd9, 8'd13, 8'd100};
    sent = 0; got = 0; order_err = 0; stable_err = 0;
    held_p = '0; held_pe = '0; held_mm = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 7);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (got >= 4 || bus.p !== 16'(sx[got]) * 16'(sy[got])) order_err++;
        got++;
      end else if (bus.out_valid) begin
        if (cyc == 2) begin
          held_p = bus.p; held_pe = bus.p_exact; held_mm = bus.mismatch;
        end else if (bus.p !== held_p || bus.p_exact !== held_pe || bus.mismatch !== held_mm) begin
          stable_err++;
        end
      end
      if (cyc == 6) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_accepted", sent, 2);
        check("stall_held_p", held_p, 15);
      end
      if (sent < 4 && bus.in_ready) begin
        bus.x = sx[sent]; bus.y = sy[sent]; bus.in_valid = 1'b1;
        sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("stall_results", got, 4);
    check("stall_order_errs", order_err, 0);
    check("stall_stable_errs", stable_err, 0);

    // cfg_load on the accept edge: that transaction keeps the old modes
    @(negedge clk);
    cfg_mode = fill(2'b11); cfg_load = 1'b1;
    bus.x = 8'd255; bus.y = 8'd255; bus.approx_en = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("same_edge_old_cfg", bus.p, 65025);
    @(negedge clk);
    check("same_edge_next_new_cfg", bus.p, 21845);

    // Reset with two transactions in flight
    @(negedge clk);
    bus.x = 8'd255; bus.y = 8'd255; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.x = 8'd3; bus.y = 8'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("inflight_out_valid", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_p", bus.p, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ov_after = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) ov_after++;
    end
    check("postrst_no_stale", ov_after, 0);
    send_and_get(8'd255, 8'd255, 1'b1, pr, pe, mm, lat);
    check("postrst_mode_exact_p", pr, 65025);
    check("postrst_mismatch", mm, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
